// File: rtl/hs_pulse_tx.sv
// hs_pulse_tx: per-channel event-to-4-phase-handshake transmitter. Each channel keeps a
// saturating count of pending events and launches one request per event.
//
//   state | meaning
//   IDLE  | no request in flight; launch when work is pending and ack_s is low
//   REQ   | req_out high, waiting for the synchronized ack to rise
//   REL   | req_out low, waiting for the synchronized ack to fall
module hs_pulse_tx #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] in_pulse,
    input  logic [CH-1:0] ack_in,
    input  logic [CH-1:0] ovf_clr,
    output logic [CH-1:0] req_out,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] done_pulse,
    output logic [CH-1:0] overflow
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PMAX = '1;

    logic [SYNC_STAGES-1:0][CH-1:0] syncFf;
    logic [CH-1:0]                  ackS;

    always_ff @(posedge clk) begin
        if (reset) begin
            syncFf <= '0;
        end else begin
            syncFf <= {syncFf[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ackS = syncFf[SYNC_STAGES-1];

    for (genvar c = 0; c < CH; c++) begin : gCh
        state_t           state, stateNext;
        logic [CNT_W-1:0] pend, pendNext;
        logic             launch, direct, inc, dec, ovfSet, doneNext;
        logic             reqQ, doneQ, ovfQ;

        always_comb begin
            stateNext = state;
            launch    = 1'b0;
            doneNext  = 1'b0;
            case (state)
                IDLE: begin
                    if ((pend != '0 || in_pulse[c]) && !ackS[c]) begin
                        launch    = 1'b1;
                        stateNext = REQ;
                    end
                end
                REQ: begin
                    if (ackS[c]) stateNext = REL;
                end
                REL: begin
                    if (!ackS[c]) begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end

        // A launch with nothing pending consumes the incoming pulse directly.
        always_comb begin
            direct   = launch && (pend == '0);
            dec      = launch && (pend != '0);
            inc      = in_pulse[c] && !direct;
            ovfSet   = 1'b0;
            pendNext = pend;
            if (inc && !dec) begin
                if (pend == PMAX) ovfSet = 1'b1;
                else              pendNext = pend + CNT_W'(1);
            end else if (dec && !inc) begin
                pendNext = pend - CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state <= IDLE;
                pend  <= '0;
                reqQ  <= 1'b0;
                doneQ <= 1'b0;
                ovfQ  <= 1'b0;
            end else begin
                state <= stateNext;
                pend  <= pendNext;
                reqQ  <= (stateNext == REQ);
                doneQ <= doneNext;
                ovfQ  <= ovfSet || (ovfQ && !ovf_clr[c]);
            end
        end

        assign req_out[c]    = reqQ;
        assign done_pulse[c] = doneQ;
        assign overflow[c]   = ovfQ;
        assign busy[c]       = (state != IDLE) || (pend != '0);
    end
endmodule

// File: tb/tb_hs_pulse_tx.sv
// Testbench for hs_pulse_tx: exact-timing vector table, then ack-model driven
// scenarios checked against a scoreboard of expected request launches.
module tb_hs_pulse_tx;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_pulse, ack_in, ovf_clr;
    logic [3:0] req_out, busy, done_pulse, overflow;

    logic [3:0] ackTab = '0, ackModel = '0, ackEn = '0;
    logic       ackModelOn = 1'b0, sbOn = 1'b0;
    logic [7:0] reqHist [4];
    int         lat [4];

    int  nVec = 0, nMis = 0, cyc = 0, minGap = 1000;
    int  riseCnt [4], doneCnt [4], highCnt [4], lowRun [4], riseAt [4], doneAt [4];
    logic [3:0] reqPrev = '0;
    byte sbQ [$];

    typedef struct packed {
        logic       rst;
        logic [3:0] inp, ack, clr, eReq, eBusy, eDone, eOvf;
    } vec_t;
    vec_t tab [$];

    assign ack_in = ackModelOn ? ackModel : ackTab;

    hs_pulse_tx #(.CH(4), .SYNC_STAGES(2), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .in_pulse(in_pulse), .ack_in(ack_in), .ovf_clr(ovf_clr),
        .req_out(req_out), .busy(busy), .done_pulse(done_pulse), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] i, input logic [3:0] a,
                                input logic [3:0] cl, input logic [3:0] er, input logic [3:0] eb,
                                input logic [3:0] ed, input logic [3:0] eo);
        vec_t v;
        v.rst = r; v.inp = i; v.ack = a; v.clr = cl;
        v.eReq = er; v.eBusy = eb; v.eDone = ed; v.eOvf = eo;
        return v;
    endfunction

    // Remote receiver: ack follows req_out delayed by lat[c] cycles.
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            reqHist[c]  = {reqHist[c][6:0], req_out[c]};
            ackModel[c] = ackEn[c] && reqHist[c][lat[c]];
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int c = 0; c < 4; c++) begin
            if (sbOn) begin
                if (req_out[c] && !reqPrev[c]) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < sbQ.size(); k++)
                        if (idx < 0 && int'(sbQ[k]) == c) idx = k;
                    check($sformatf("sb_rise_ch%0d", c), 32'(idx >= 0), 32'd1);
                    if (idx >= 0) sbQ.delete(idx);
                    if (riseCnt[c] > 0 && lowRun[c] < minGap) minGap = lowRun[c];
                    riseCnt[c]++;
                    riseAt[c] = cyc;
                end
                if (req_out[c]) begin
                    highCnt[c]++;
                    lowRun[c] = 0;
                end else begin
                    lowRun[c]++;
                end
                if (done_pulse[c]) begin
                    doneCnt[c]++;
                    doneAt[c] = cyc;
                end
            end
            reqPrev[c] = req_out[c];
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic r, input logic [3:0] p, input logic [3:0] cl);
        reset = r; in_pulse = p; ovf_clr = cl;
        if (sbOn && !r)
            for (int k = 0; k < 4; k++) if (p[k]) sbQ.push_back(byte'(k));
        tick();
    endtask

    task automatic clearSb();
        sbQ.delete();
        minGap = 1000;
        for (int c = 0; c < 4; c++) begin
            riseCnt[c] = 0; doneCnt[c] = 0; highCnt[c] = 0; lowRun[c] = 0;
            riseAt[c] = 0; doneAt[c] = 0;
        end
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((busy != 4'h0 || req_out != 4'h0) && n < 400) begin
            tick();
            n++;
        end
        check({name, "_idle_in_time"}, 32'(n < 400), 32'd1);
        repeat (4) tick();
    endtask

    function automatic int countQ(input int c);
        int n = 0;
        foreach (sbQ[k]) if (int'(sbQ[k]) == c) n++;
        return n;
    endfunction

    initial begin
        reset = 1'b1; in_pulse = '0; ovf_clr = '0;
        for (int c = 0; c < 4; c++) begin
            reqHist[c] = '0;
            lat[c] = 1;
        end
        clearSb();

        //            rst  in    ack   clr   req   busy  done  ovf
        tab.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0));
        tab.push_back(mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));

        @(negedge clk);
        for (int i = 0; i < tab.size(); i++) begin
            ackTab = tab[i].ack;
            step(tab[i].rst, tab[i].inp, tab[i].clr);
            check($sformatf("tab%0d_req", i),  32'(req_out),    32'(tab[i].eReq));
            check($sformatf("tab%0d_busy", i), 32'(busy),       32'(tab[i].eBusy));
            check($sformatf("tab%0d_done", i), 32'(done_pulse), 32'(tab[i].eDone));
            check($sformatf("tab%0d_ovf", i),  32'(overflow),   32'(tab[i].eOvf));
        end

        ackModelOn = 1'b1;
        sbOn = 1'b1;

        // Back-to-back events on channel 1.
        clearSb();
        ackEn = 4'hF;
        repeat (3) step(0, 4'h2, 4'h0);
        step(0, 4'h0, 4'h0);
        waitIdle("b2b");
        check("b2b_rises", riseCnt[1], 3);
        check("b2b_dones", doneCnt[1], 3);
        check("b2b_high_cycles", highCnt[1], 12);
        check("b2b_gap_ok", 32'(minGap >= 1 && minGap < 1000), 32'd1);
        check("b2b_other_rises", riseCnt[0] + riseCnt[2] + riseCnt[3], 0);
        check("b2b_sb_empty", sbQ.size(), 0);

        // Saturation on channel 2 with its receiver silent.
        clearSb();
        ackEn = 4'b1011;
        repeat (8) step(0, 4'h4, 4'h0);
        check("sat_ovf_at_full", 32'(overflow), 32'h0);
        step(0, 4'h4, 4'h0);
        check("sat_ovf_on_loss", 32'(overflow), 32'h4);
        step(0, 4'h4, 4'h0);
        check("sat_req_held", 32'(req_out), 32'h4);
        check("sat_busy", 32'(busy), 32'h4);
        step(0, 4'h0, 4'h0);
        ackEn = 4'hF;
        waitIdle("sat");
        check("sat_rises", riseCnt[2], 8);
        check("sat_dones", doneCnt[2], 8);
        check("sat_dropped", countQ(2), 2);
        check("sat_ovf_sticky", 32'(overflow), 32'h4);
        step(0, 4'h0, 4'h4);
        check("sat_ovf_cleared", 32'(overflow), 32'h0);

        // Clear coinciding with a new loss: the set must win.
        clearSb();
        ackEn = 4'b1011;
        repeat (8) step(0, 4'h4, 4'h0);
        step(0, 4'h4, 4'h4);
        check("ovf_set_wins", 32'(overflow), 32'h4);
        step(0, 4'h0, 4'h4);
        check("ovf_clear_after", 32'(overflow), 32'h0);
        step(0, 4'h0, 4'h0);
        ackEn = 4'hF;
        waitIdle("setwin");
        check("setwin_rises", riseCnt[2], 8);
        check("setwin_dropped", countQ(2), 1);

        // Reset while channel 0 is in REQ with two events pending.
        clearSb();
        ackEn = 4'b1110;
        repeat (3) step(0, 4'h1, 4'h0);
        check("rst_pre_req", 32'(req_out), 32'h1);
        check("rst_pre_busy", 32'(busy), 32'h1);
        step(1, 4'h1, 4'h0);
        check("rst_req", 32'(req_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done_pulse), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        clearSb();
        ackEn = 4'hF;
        repeat (30) step(0, 4'h0, 4'h0);
        check("rst_no_relaunch", riseCnt[0], 0);
        check("rst_no_done", doneCnt[0], 0);
        check("rst_idle", 32'(busy), 32'h0);

        // All channels at once with ack latencies 1..4.
        clearSb();
        for (int c = 0; c < 4; c++) lat[c] = c + 1;
        step(0, 4'hF, 4'h0);
        step(0, 4'h0, 4'h0);
        waitIdle("conc");
        for (int c = 0; c < 4; c++) begin
            check($sformatf("conc_rise_ch%0d", c), riseCnt[c], 1);
            check($sformatf("conc_done_ch%0d", c), doneCnt[c], 1);
            check($sformatf("conc_high_ch%0d", c), highCnt[c], lat[c] + 3);
            check($sformatf("conc_span_ch%0d", c), doneAt[c] - riseAt[c], 2 * lat[c] + 6);
        end
        check("conc_sb_empty", sbQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
